aggregator_slot_scheduler: RTL and testbench
============================================

Name: aggregator_slot_scheduler

Overview:
- Upstream feeder and result collector for binary_aggregator_2d.
- Buffers up to SLOT_CNT pending requests (key + payload) in a slot table and presents a one-cycle candidate snapshot to the aggregator.
- Waits the aggregator's configured pipeline latency, captures the winner, frees the winning slot and offers it downstream on a valid/ready port.
- Exactly one arbitration in flight at a time, so aggregator latency never yields stale winners.

Parameters:
- SLOT_CNT, 5, number of slots; equals the aggregator CANDIDATE_CNT.
- KEY_WIDTH, 6, compare key width.
- DATA_WIDTH, 16, payload width.
- IDX_WIDTH, log2(SLOT_CNT), slot index width.
- AGG_LATENCY, 0, FF stages between aggregator input and output (0 = combinational aggregator).

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset.
- in_vld  input  1  request valid.
- in_rdy  output  1  a free slot exists.
- in_key  input  KEY_WIDTH  request key.
- in_data  input  DATA_WIDTH  request payload.
- cand_vld  output  SLOT_CNT  per-slot candidate valid to aggregator.
- cand_key  output  KEY_WIDTH x SLOT_CNT (unpacked)  slot keys.
- cand_data  output  (IDX_WIDTH+DATA_WIDTH) x SLOT_CNT (unpacked)  {payload, slot index}, index in the low bits.
- win_vld  input  1  aggregator winner valid.
- win_key  input  KEY_WIDTH  aggregator winner key.
- win_data  input  IDX_WIDTH+DATA_WIDTH  aggregator winner data.
- out_vld  output  1  result valid.
- out_rdy  input  1  downstream ready.
- out_key  output  KEY_WIDTH  winning key.
- out_data  output  DATA_WIDTH  winning payload.
- out_idx  output  IDX_WIDTH  winning slot.
- err  output  1  sticky: capture with win_vld=0 or an index not in flight.

Behaviour:
- Reset: asynchronous, active-low rst_n; clock clk.
  - All slot valid bits 0; state IDLE; counter 0.
  - Outputs: out_vld=0, out_key/out_data/out_idx=0, err=0, cand_vld=0, in_rdy=1.
- Ingress:
  - in_rdy = OR of free slots; combinational from registered slot state only.
  - in_vld && in_rdy writes the lowest-index free slot at the clock edge.
  - A slot freed by a capture becomes writable the next cycle.
  - A slot still in flight is never overwritten.
- Candidate outputs:
  - cand_key/cand_data are always driven from slot storage.
  - cand_vld = slot valid mask during ISSUE, else 0.
- FSM:
  - IDLE -> ISSUE when any slot is valid.
  - ISSUE (1 cycle): snapshot mask presented.
    - AGG_LATENCY=0: capture at the end of ISSUE, go HOLD.
    - Otherwise: load cnt=AGG_LATENCY-1, go WAIT.
  - WAIT: cnt decrements; when cnt==0, capture and go HOLD.
  - HOLD: out_vld=1, out_* stable.
    - On out_rdy: go ISSUE if any slot is valid (including writes in the same cycle), else IDLE.
- Capture:
  - Register win_key, win_data payload and index into out_*.
  - Clear slot[index] valid.
  - If win_vld=0 or slot[index] is not valid: set err, do not clear any slot, go IDLE with out_vld=0.
- Simultaneous events:
  - Ingress write in the same cycle as capture is allowed; the write selects from the pre-clear free mask.
  - A write during ISSUE or WAIT is excluded from the current snapshot and is eligible for the next ISSUE.
- Throughput: at most one result per AGG_LATENCY+2 cycles when out_rdy is held high.
- Full: in_rdy=0 when all slots are valid; in_vld is ignored.
- Mid-operation reset: all in-flight state is discarded; the next ISSUE occurs no earlier than 2 cycles after deassertion.

Decomposition:
- Shared package aggregator_pkg holds:
  - clog2 function for IDX_WIDTH.
  - FSM state encoding constants (IDLE, ISSUE, WAIT, HOLD).
  - Candidate data layout constants (index in low bits).
- One sub-module: slot_free_finder, a lowest-set-bit priority encoder over ~slot_vld producing the index and an any-free flag.

Test Plan:
- Single request, AGG_LATENCY=0: write key=5 data=0x1234 into an empty table -> cand_vld=5'b00001 for exactly one cycle; out_vld rises the next cycle with out_key=5, out_data=0x1234, out_idx=0; slot 0 freed.
- Fill the table: 5 writes with out_rdy=0 -> slots 0..4 valid and in_rdy=0; a 6th in_vld is ignored; after one result pops, in_rdy returns to 1 the next cycle.
- AGG_LATENCY=2: keys 9,3,7 in slots 0..2, min-key comparator, out_rdy=1 -> results in order key 3, 7, 9, each 4 cycles apart; cand_vld is high 1 cycle per round.
- Backpressure: out_rdy=0 for 10 cycles during HOLD -> out_* stable, no new ISSUE; out_rdy=1 -> ISSUE on the next cycle.
- Write during WAIT with AGG_LATENCY=3: the new slot is absent from the current cand_vld snapshot and appears in the next ISSUE.
- Error injection: force win_vld=0 at capture -> err=1 (sticky), no slot cleared, FSM returns to IDLE; err clears only on rst_n.

Source files
------------

// File: rtl/aggregator_pkg.sv
// Shared types and helpers for the aggregator slot scheduler.
// Candidate data layout: slot index in the low bits, payload above it.
package aggregator_pkg;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return (r < 1) ? 1 : r;
   endfunction

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      HOLD  = 2'd3
   } sched_state_e;

   localparam int CAND_IDX_LSB = 0;

endpackage

// File: rtl/slot_free_finder.sv
// Lowest-index free slot finder over the slot valid mask.
module slot_free_finder
   import aggregator_pkg::*;
#(
   parameter int SLOT_CNT  = 5,
   parameter int IDX_WIDTH = clog2(SLOT_CNT)
) (
   input  logic [SLOT_CNT-1:0]  slot_vld,
   output logic [IDX_WIDTH-1:0] free_idx,
   output logic                 any_free
);

   always_comb begin
      free_idx = '0;
      any_free = 1'b0;
      for (int i = SLOT_CNT - 1; i >= 0; i--) begin
         if (!slot_vld[i]) begin
            free_idx = IDX_WIDTH'(i);
            any_free = 1'b1;
         end
      end
   end

endmodule

// File: rtl/aggregator_slot_scheduler.sv
// Slot table feeding binary_aggregator_2d one snapshot at a time and
// returning each winner on a valid/ready port.
module aggregator_slot_scheduler
   import aggregator_pkg::*;
#(
   parameter int SLOT_CNT    = 5,
   parameter int KEY_WIDTH   = 6,
   parameter int DATA_WIDTH  = 16,
   parameter int IDX_WIDTH   = clog2(SLOT_CNT),
   parameter int AGG_LATENCY = 0
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            in_vld,
   output logic                            in_rdy,
   input  logic [KEY_WIDTH-1:0]            in_key,
   input  logic [DATA_WIDTH-1:0]           in_data,
   output logic [SLOT_CNT-1:0]             cand_vld,
   output logic [KEY_WIDTH-1:0]            cand_key  [SLOT_CNT],
   output logic [IDX_WIDTH+DATA_WIDTH-1:0] cand_data [SLOT_CNT],
   input  logic                            win_vld,
   input  logic [KEY_WIDTH-1:0]            win_key,
   input  logic [IDX_WIDTH+DATA_WIDTH-1:0] win_data,
   output logic                            out_vld,
   input  logic                            out_rdy,
   output logic [KEY_WIDTH-1:0]            out_key,
   output logic [DATA_WIDTH-1:0]           out_data,
   output logic [IDX_WIDTH-1:0]            out_idx,
   output logic                            err
);

   localparam int CNT_W    = clog2(AGG_LATENCY + 1);
   localparam int IDX_SPAN = 1 << IDX_WIDTH;
   localparam int PAY_LSB  = CAND_IDX_LSB + IDX_WIDTH;

   sched_state_e state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [SLOT_CNT-1:0]   slot_vld;
   logic [SLOT_CNT-1:0]   snap_q;
   logic [KEY_WIDTH-1:0]  key_q  [SLOT_CNT];
   logic [DATA_WIDTH-1:0] data_q [SLOT_CNT];

   logic [IDX_WIDTH-1:0]  free_idx;
   logic                  any_free;
   logic                  wr;
   logic [SLOT_CNT-1:0]   wr_mask;
   logic [SLOT_CNT-1:0]   clr_mask;
   logic [SLOT_CNT-1:0]   inflight;
   logic [IDX_SPAN-1:0]   inflight_x;
   logic [IDX_WIDTH-1:0]  win_idx;
   logic [DATA_WIDTH-1:0] win_pay;
   logic                  capture;
   logic                  cap_ok;

   slot_free_finder #(
      .SLOT_CNT  (SLOT_CNT),
      .IDX_WIDTH (IDX_WIDTH)
   ) u_free (
      .slot_vld (slot_vld),
      .free_idx (free_idx),
      .any_free (any_free)
   );

   assign in_rdy  = any_free;
   assign wr      = in_vld & any_free;
   assign wr_mask = wr ? SLOT_CNT'(1) << free_idx : '0;

   assign win_idx = win_data[CAND_IDX_LSB +: IDX_WIDTH];
   assign win_pay = win_data[PAY_LSB +: DATA_WIDTH];

   // Only slots from the presented snapshot may legitimately win.
   assign inflight   = (state_q == ISSUE) ? slot_vld : snap_q;
   assign inflight_x = IDX_SPAN'(inflight);
   assign cap_ok     = win_vld & inflight_x[win_idx];
   assign clr_mask   = (capture && cap_ok) ? SLOT_CNT'(1) << win_idx : '0;

   assign cand_vld = (state_q == ISSUE) ? slot_vld : '0;
   assign out_vld  = (state_q == HOLD);

   always_comb begin
      for (int i = 0; i < SLOT_CNT; i++) begin
         cand_key[i]  = key_q[i];
         cand_data[i] = {data_q[i], IDX_WIDTH'(i)};
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      capture = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (|slot_vld) state_d = ISSUE;
         end
         ISSUE: begin
            if (AGG_LATENCY == 0) begin
               capture = 1'b1;
            end else begin
               cnt_d   = CNT_W'(AGG_LATENCY - 1);
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (cnt_q == '0) capture = 1'b1;
            else cnt_d = cnt_q - CNT_W'(1);
         end
         HOLD: begin
            if (out_rdy) state_d = (|(slot_vld | wr_mask)) ? ISSUE : IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (capture) state_d = cap_ok ? HOLD : IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         slot_vld <= '0;
         snap_q   <= '0;
         out_key  <= '0;
         out_data <= '0;
         out_idx  <= '0;
         err      <= 1'b0;
         for (int i = 0; i < SLOT_CNT; i++) begin
            key_q[i]  <= '0;
            data_q[i] <= '0;
         end
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         slot_vld <= (slot_vld & ~clr_mask) | wr_mask;
         if (state_q == ISSUE) snap_q <= slot_vld;
         if (wr) begin
            key_q[free_idx]  <= in_key;
            data_q[free_idx] <= in_data;
         end
         if (capture && cap_ok) begin
            out_key  <= win_key;
            out_data <= win_pay;
            out_idx  <= win_idx;
         end
         if (capture && !cap_ok) err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_aggregator_slot_scheduler.sv
// Bench for aggregator_slot_scheduler: a min-key aggregator model drives
// two instances (latency 2 and latency 0).
module tb_aggregator_slot_scheduler;

   localparam int N   = 5;
   localparam int KW  = 6;
   localparam int DW  = 16;
   localparam int IW  = 3;
   localparam int CW  = IW + DW;
   localparam int LAT = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic          v;
      logic [KW-1:0] k;
      logic [CW-1:0] d;
   } win_t;

   function automatic win_t agg_min(input logic [N-1:0] v,
                                    input logic [KW-1:0] k [N],
                                    input logic [CW-1:0] d [N]);
      win_t w;
      w = '0;
      for (int i = 0; i < N; i++)
         if (v[i] && (!w.v || k[i] < w.k)) begin
            w.v = 1'b1;
            w.k = k[i];
            w.d = d[i];
         end
      return w;
   endfunction

   // instance B: AGG_LATENCY = LAT
   logic          b_in_vld, b_in_rdy, b_out_vld, b_out_rdy, b_err;
   logic [KW-1:0] b_in_key, b_out_key;
   logic [DW-1:0] b_in_data, b_out_data;
   logic [IW-1:0] b_out_idx;
   logic [N-1:0]  b_cand_vld;
   logic [KW-1:0] b_cand_key [N];
   logic [CW-1:0] b_cand_data [N];
   win_t          b_w;
   win_t          b_p0 = '0;
   win_t          b_p1 = '0;

   always_comb b_w = agg_min(b_cand_vld, b_cand_key, b_cand_data);
   always @(posedge clk) begin
      b_p0 <= b_w;
      b_p1 <= b_p0;
   end

   aggregator_slot_scheduler #(
      .SLOT_CNT(N), .KEY_WIDTH(KW), .DATA_WIDTH(DW),
      .IDX_WIDTH(IW), .AGG_LATENCY(LAT)
   ) u_b (
      .clk(clk), .rst_n(rst_n),
      .in_vld(b_in_vld), .in_rdy(b_in_rdy),
      .in_key(b_in_key), .in_data(b_in_data),
      .cand_vld(b_cand_vld), .cand_key(b_cand_key),
      .cand_data(b_cand_data),
      .win_vld(b_p1.v), .win_key(b_p1.k), .win_data(b_p1.d),
      .out_vld(b_out_vld), .out_rdy(b_out_rdy),
      .out_key(b_out_key), .out_data(b_out_data),
      .out_idx(b_out_idx), .err(b_err)
   );

   // instance A: combinational aggregator, with win_vld override
   logic          a_in_vld, a_in_rdy, a_out_vld, a_out_rdy, a_err;
   logic [KW-1:0] a_in_key, a_out_key;
   logic [DW-1:0] a_in_data, a_out_data;
   logic [IW-1:0] a_out_idx;
   logic [N-1:0]  a_cand_vld;
   logic [KW-1:0] a_cand_key [N];
   logic [CW-1:0] a_cand_data [N];
   win_t          a_w;
   logic          force_nv;

   always_comb a_w = agg_min(a_cand_vld, a_cand_key, a_cand_data);

   aggregator_slot_scheduler #(
      .SLOT_CNT(N), .KEY_WIDTH(KW), .DATA_WIDTH(DW),
      .IDX_WIDTH(IW), .AGG_LATENCY(0)
   ) u_a (
      .clk(clk), .rst_n(rst_n),
      .in_vld(a_in_vld), .in_rdy(a_in_rdy),
      .in_key(a_in_key), .in_data(a_in_data),
      .cand_vld(a_cand_vld), .cand_key(a_cand_key),
      .cand_data(a_cand_data),
      .win_vld(a_w.v & ~force_nv), .win_key(a_w.k), .win_data(a_w.d),
      .out_vld(a_out_vld), .out_rdy(a_out_rdy),
      .out_key(a_out_key), .out_data(a_out_data),
      .out_idx(a_out_idx), .err(a_err)
   );

   int n_pass = 0;
   int n_tot  = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      b_in_vld = 1'b0; b_in_key = '0; b_in_data = '0; b_out_rdy = 1'b0;
      a_in_vld = 1'b0; a_in_key = '0; a_in_data = '0; a_out_rdy = 1'b0;
      force_nv = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // reference model for instance B: slot table plus age of the round
   logic [N-1:0]  m_vld;
   logic [KW-1:0] m_key [N];
   logic [DW-1:0] m_dat [N];
   logic [N-1:0]  snap;
   int            age;
   logic [KW-1:0] h_key;
   logic [DW-1:0] h_dat;
   logic [IW-1:0] h_idx;

   task automatic model_reset();
      m_vld = '0; snap = '0; age = -1;
      h_key = '0; h_dat = '0; h_idx = '0;
   endtask

   task automatic model_check();
      chk("rnd_in_rdy", 32'(b_in_rdy), 32'(!(&m_vld)));
      chk("rnd_cand_vld", 32'(b_cand_vld), 32'((age == 0) ? m_vld : '0));
      chk("rnd_out_vld", 32'(b_out_vld), 32'(age == LAT + 1));
      chk("rnd_out_key", 32'(b_out_key), 32'(h_key));
      chk("rnd_out_data", 32'(b_out_data), 32'(h_dat));
      chk("rnd_out_idx", 32'(b_out_idx), 32'(h_idx));
      chk("rnd_err", 32'(b_err), 32'(0));
   endtask

   task automatic model_step();
      int  f, w;
      bit  pop;
      f = -1; pop = 0;
      for (int i = N - 1; i >= 0; i--) if (!m_vld[i]) f = i;
      if (age == -1) begin
         age = (|m_vld) ? 0 : -1;
      end else if (age <= LAT) begin
         if (age == 0) snap = m_vld;
         if (age == LAT) begin
            w = -1;
            for (int i = 0; i < N; i++)
               if (snap[i] && (w < 0 || m_key[i] < m_key[w])) w = i;
            h_key = m_key[w]; h_dat = m_dat[w]; h_idx = IW'(w);
            m_vld[w] = 1'b0;
            age = LAT + 1;
         end else begin
            age++;
         end
      end else if (b_out_rdy) begin
         pop = 1;
      end
      if (b_in_vld && f >= 0) begin
         m_vld[f] = 1'b1; m_key[f] = b_in_key; m_dat[f] = b_in_data;
      end
      if (pop) age = (|m_vld) ? 0 : -1;
   endtask

   typedef struct {
      logic          iv;
      logic [KW-1:0] ik;
      logic          ordy;
      logic          e_rdy;
      logic [N-1:0]  e_cand;
      logic          e_ov;
      logic [KW-1:0] e_key;
      logic [IW-1:0] e_idx;
   } vec_t;

   vec_t tv [13];

   initial begin
      tv[0]  = '{1'b1, 6'd9,  1'b0, 1'b1, 5'b00000, 1'b0, 6'd0, 3'd0};
      tv[1]  = '{1'b1, 6'd3,  1'b0, 1'b1, 5'b00000, 1'b0, 6'd0, 3'd0};
      tv[2]  = '{1'b1, 6'd7,  1'b0, 1'b1, 5'b00011, 1'b0, 6'd0, 3'd0};
      tv[3]  = '{1'b1, 6'd12, 1'b0, 1'b1, 5'b00000, 1'b0, 6'd0, 3'd0};
      tv[4]  = '{1'b1, 6'd20, 1'b0, 1'b1, 5'b00000, 1'b0, 6'd0, 3'd0};
      tv[5]  = '{1'b1, 6'd1,  1'b0, 1'b1, 5'b00000, 1'b1, 6'd3, 3'd1};
      tv[6]  = '{1'b1, 6'd2,  1'b0, 1'b0, 5'b00000, 1'b1, 6'd3, 3'd1};
      tv[7]  = '{1'b1, 6'd2,  1'b1, 1'b0, 5'b00000, 1'b1, 6'd3, 3'd1};
      tv[8]  = '{1'b1, 6'd2,  1'b1, 1'b0, 5'b11111, 1'b0, 6'd0, 3'd0};
      tv[9]  = '{1'b1, 6'd2,  1'b1, 1'b0, 5'b00000, 1'b0, 6'd0, 3'd0};
      tv[10] = '{1'b1, 6'd2,  1'b1, 1'b0, 5'b00000, 1'b0, 6'd0, 3'd0};
      tv[11] = '{1'b1, 6'd2,  1'b1, 1'b1, 5'b00000, 1'b1, 6'd1, 3'd1};
      tv[12] = '{1'b0, 6'd0,  1'b1, 1'b0, 5'b11111, 1'b0, 6'd0, 3'd0};

      do_reset();
      chk("rst_in_rdy", 32'(b_in_rdy), 32'(1));
      chk("rst_cand_vld", 32'(b_cand_vld), 32'(0));
      chk("rst_out_vld", 32'(b_out_vld), 32'(0));
      chk("rst_out_key", 32'(b_out_key), 32'(0));
      chk("rst_out_data", 32'(b_out_data), 32'(0));
      chk("rst_out_idx", 32'(b_out_idx), 32'(0));
      chk("rst_err", 32'(b_err), 32'(0));

      // fill, full, backpressure and writes during ISSUE/WAIT
      for (int i = 0; i < 13; i++) begin
         chk($sformatf("tv%0d_in_rdy", i), 32'(b_in_rdy), 32'(tv[i].e_rdy));
         chk($sformatf("tv%0d_cand", i), 32'(b_cand_vld), 32'(tv[i].e_cand));
         chk($sformatf("tv%0d_out_vld", i), 32'(b_out_vld), 32'(tv[i].e_ov));
         if (tv[i].e_ov) begin
            chk($sformatf("tv%0d_key", i), 32'(b_out_key), 32'(tv[i].e_key));
            chk($sformatf("tv%0d_idx", i), 32'(b_out_idx), 32'(tv[i].e_idx));
            chk($sformatf("tv%0d_data", i), 32'(b_out_data),
                32'(16'hA000 + 16'(tv[i].e_key)));
         end
         b_in_vld  = tv[i].iv;
         b_in_key  = tv[i].ik;
         b_in_data = 16'hA000 + 16'(tv[i].ik);
         b_out_rdy = tv[i].ordy;
         tick();
      end

      // single request and error injection on the zero-latency instance
      do_reset();
      chk("a_rst_in_rdy", 32'(a_in_rdy), 32'(1));
      chk("a_rst_err", 32'(a_err), 32'(0));
      a_in_vld = 1'b1; a_in_key = 6'd5; a_in_data = 16'h1234;
      tick();
      a_in_vld = 1'b0;
      chk("a_c1_cand", 32'(a_cand_vld), 32'(0));
      tick();
      chk("a_c2_cand", 32'(a_cand_vld), 32'(5'b00001));
      chk("a_c2_out_vld", 32'(a_out_vld), 32'(0));
      tick();
      chk("a_c3_cand", 32'(a_cand_vld), 32'(0));
      chk("a_c3_out_vld", 32'(a_out_vld), 32'(1));
      chk("a_c3_key", 32'(a_out_key), 32'(5));
      chk("a_c3_data", 32'(a_out_data), 32'(16'h1234));
      chk("a_c3_idx", 32'(a_out_idx), 32'(0));
      a_out_rdy = 1'b1;
      tick();
      chk("a_c4_out_vld", 32'(a_out_vld), 32'(0));
      a_out_rdy = 1'b0;
      a_in_vld = 1'b1; a_in_key = 6'd8; a_in_data = 16'h00BE;
      force_nv = 1'b1;
      tick();
      a_in_vld = 1'b0;
      tick();
      chk("a_c6_cand", 32'(a_cand_vld), 32'(5'b00001));
      chk("a_c6_err", 32'(a_err), 32'(0));
      tick();
      chk("a_c7_err", 32'(a_err), 32'(1));
      chk("a_c7_out_vld", 32'(a_out_vld), 32'(0));
      chk("a_c7_cand", 32'(a_cand_vld), 32'(0));
      force_nv = 1'b0;
      tick();
      chk("a_c8_cand_kept", 32'(a_cand_vld), 32'(5'b00001));
      tick();
      chk("a_c9_out_vld", 32'(a_out_vld), 32'(1));
      chk("a_c9_key", 32'(a_out_key), 32'(8));
      chk("a_c9_err_sticky", 32'(a_err), 32'(1));
      a_out_rdy = 1'b1;
      tick();
      chk("a_c10_err_sticky", 32'(a_err), 32'(1));
      do_reset();
      chk("a_err_cleared", 32'(a_err), 32'(0));

      // randomized traffic against the reference model, with a mid-run reset
      do_reset();
      model_reset();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (cyc == 1500) begin
            do_reset();
            model_reset();
         end
         model_check();
         b_in_vld  = ($urandom % 3) != 0;
         b_in_key  = KW'($urandom_range(0, 63));
         b_in_data = DW'($urandom);
         b_out_rdy = (cyc % 200 < 40) ? 1'b0 : (($urandom % 4) != 0);
         model_step();
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
